// File: rtl/xbar_sched_matrix.sv
// xbar_sched_matrix: per-bank round-robin scheduler over per-channel pending-entry bitmaps with aging override
module xbar_sched_matrix #(
  parameter int NUM_CH = 3,
  parameter int NUM_BANK = 4,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 32,
  parameter int BANK_LSB = 8,
  parameter int MAX_WAIT = 15,
  localparam int PW = $clog2(DEPTH),
  localparam int BW = $clog2(NUM_BANK),
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_push_valid,
  input  logic [NUM_CH-1:0]                ch_push_ready,
  input  logic [NUM_CH*ADDR_W-1:0]         ch_push_addr,
  input  logic [NUM_CH*PW-1:0]             ch_w_ptr,
  input  logic [NUM_CH*PW-1:0]             ch_r_ptr,
  input  logic [NUM_CH-1:0]                ch_flush,
  output logic [NUM_BANK-1:0]              bank_req_valid,
  input  logic [NUM_BANK-1:0]              bank_req_ready,
  output logic [NUM_BANK*NUM_CH-1:0]       bank_ch_1hot,
  output logic [NUM_CH*NUM_BANK*DEPTH-1:0] ch_bank_entry_1hot,
  output logic [NUM_CH*NUM_BANK-1:0]       ch_bank_last_pop,
  output logic [NUM_CH*(PW+1)-1:0]         ch_pending_cnt,
  output logic [NUM_BANK-1:0]              bank_starved
);
  function automatic logic [CW-1:0] ch_mod(input int k);
    return CW'(k % NUM_CH);
  endfunction
  logic [DEPTH-1:0] v_q [NUM_CH][NUM_BANK];
  logic [DEPTH-1:0] v_d [NUM_CH][NUM_BANK];
  logic [DEPTH-1:0] sel [NUM_CH][NUM_BANK];
  logic [7:0] wait_q [NUM_CH][NUM_BANK];
  logic [7:0] wait_d [NUM_CH][NUM_BANK];
  logic push [NUM_CH][NUM_BANK];
  logic pop [NUM_CH][NUM_BANK];
  logic [CW-1:0] rr_q [NUM_BANK];
  logic [CW-1:0] rr_d [NUM_BANK];
  logic [CW-1:0] hold_ch_q [NUM_BANK];
  logic [CW-1:0] hold_ch_d [NUM_BANK];
  logic [CW-1:0] rr_gnt [NUM_BANK];
  logic [CW-1:0] age_gnt [NUM_BANK];
  logic [CW-1:0] gnt [NUM_BANK];
  logic [NUM_CH-1:0] req [NUM_BANK];
  logic [NUM_BANK-1:0] hold_q, hold_d, hs;
  logic [NUM_CH-1:0] dup;
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < NUM_BANK; b++) begin
        sel[c][b] = '0;
        for (int i = DEPTH-1; i >= 0; i--)
          sel[c][b] = v_q[c][b][PW'(ch_r_ptr[c*PW +: PW] + PW'(i))] ? DEPTH'(1) << PW'(ch_r_ptr[c*PW +: PW] + PW'(i)) : sel[c][b];
      end
  end
  always_comb begin
    bank_req_valid = '0;
    bank_starved = '0;
    hs = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      req[b] = '0;
      rr_gnt[b] = '0;
      age_gnt[b] = '0;
      for (int c = 0; c < NUM_CH; c++)
        req[b][c] = |v_q[c][b];
      for (int i = NUM_CH-1; i >= 0; i--)
        rr_gnt[b] = req[b][ch_mod(int'(rr_q[b]) + i)] ? ch_mod(int'(rr_q[b]) + i) : rr_gnt[b];
      for (int c = NUM_CH-1; c >= 0; c--) begin
        bank_starved[b] = bank_starved[b] | (req[b][c] && wait_q[c][b] == 8'(MAX_WAIT));
        age_gnt[b] = (req[b][c] && wait_q[c][b] == 8'(MAX_WAIT)) ? CW'(c) : age_gnt[b];
      end
      gnt[b] = bank_starved[b] ? age_gnt[b] : (hold_q[b] && req[b][hold_ch_q[b]]) ? hold_ch_q[b] : rr_gnt[b];
      bank_req_valid[b] = |req[b];
      hs[b] = bank_req_valid[b] & bank_req_ready[b];
    end
  end
  always_comb begin
    bank_ch_1hot = '0;
    ch_bank_entry_1hot = '0;
    ch_bank_last_pop = '0;
    ch_pending_cnt = '0;
    dup = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      rr_d[b] = (hs[b] && !bank_starved[b]) ? ch_mod(int'(gnt[b]) + 1) : rr_q[b];
      hold_d[b] = bank_req_valid[b] & ~bank_req_ready[b];
      hold_ch_d[b] = gnt[b];
    end
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < NUM_BANK; b++) begin
        push[c][b] = ch_push_valid[c] & ch_push_ready[c] & (ch_push_addr[c*ADDR_W+BANK_LSB +: BW] == BW'(b));
        pop[c][b] = hs[b] && gnt[b] == CW'(c);
        v_d[c][b] = (ch_flush[c] ? '0 : v_q[c][b] & ~(pop[c][b] ? sel[c][b] : '0))
                  | (push[c][b] ? DEPTH'(1) << ch_w_ptr[c*PW +: PW] : '0);
        wait_d[c][b] = (ch_flush[c] || !req[b][c] || pop[c][b]) ? 8'd0
                     : wait_q[c][b] + 8'(wait_q[c][b] != 8'(MAX_WAIT));
        dup[c] = dup[c] | (push[c][b] & v_q[c][b][ch_w_ptr[c*PW +: PW]] & ~ch_flush[c]
                 & ~(pop[c][b] & sel[c][b][ch_w_ptr[c*PW +: PW]]));
        bank_ch_1hot[b*NUM_CH + c] = bank_req_valid[b] && gnt[b] == CW'(c);
        ch_bank_entry_1hot[(c*NUM_BANK+b)*DEPTH +: DEPTH] = sel[c][b];
        ch_bank_last_pop[c*NUM_BANK+b] = ~v_q[c][b][ch_r_ptr[c*PW +: PW]];
        ch_pending_cnt[c*(PW+1) +: PW+1] = ch_pending_cnt[c*(PW+1) +: PW+1] + (PW+1)'($countones(v_q[c][b]));
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '{default: '0};
      wait_q <= '{default: '0};
      rr_q <= '{default: '0};
      hold_ch_q <= '{default: '0};
      hold_q <= '0;
    end else begin
      v_q <= v_d;
      wait_q <= wait_d;
      rr_q <= rr_d;
      hold_ch_q <= hold_ch_d;
      hold_q <= hold_d;
    end
  end
  always @(posedge clk)
    if (!rst) assert (dup == '0);
endmodule
